// File: rtl/posit_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : posit_word_packer
// Purpose  : Packs LANES consecutive P-bit posits into one wide output word.
//            Frame-end flush pads unused lanes with zeros. NaR flag is sticky.
// Revision : 1.0  initial release
// ============================================================================
module posit_word_packer #(
    parameter int P     = 16,
    parameter int LANES = 4,
    parameter int OUT_W = P * LANES,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [P-1:0]     in_posit,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [LANES-1:0] out_keep,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             nar_seen
);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [P-1:0]     C_NAR       = {1'b1, {(P-1){1'b0}}};
    localparam logic [CNT_W-1:0] C_LAST_LANE = CNT_W'(LANES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   lane_cnt_q, lane_cnt_d;
    logic [OUT_W-1:0]   acc_q, acc_d;
    logic [LANES-1:0]   keep_acc_q, keep_acc_d;
    logic               last_acc_q, last_acc_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic [LANES-1:0]   out_keep_q, out_keep_d;
    logic               out_last_q, out_last_d;
    logic               out_valid_q, out_valid_d;
    logic               nar_q, nar_d;

    logic               w_slot_free;
    logic               w_word_done;
    logic [OUT_W-1:0]   w_acc_merge;
    logic [LANES-1:0]   w_keep_merge;

    always_comb begin
        state_d     = state_q;
        lane_cnt_d  = lane_cnt_q;
        acc_d       = acc_q;
        keep_acc_d  = keep_acc_q;
        last_acc_d  = last_acc_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        nar_d       = nar_q;

        w_slot_free  = !out_valid_q || out_ready;
        w_word_done  = (lane_cnt_q == C_LAST_LANE) || in_last;
        w_acc_merge  = acc_q;
        w_keep_merge = keep_acc_q;
        for (int l = 0; l < LANES; l++) begin
            if (lane_cnt_q == CNT_W'(l)) begin
                w_acc_merge[P*l +: P] = in_posit;
                w_keep_merge[l]       = 1'b1;
            end
        end

        // A drain this cycle is overridden below if a new word loads.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    if (in_posit == C_NAR) begin
                        nar_d = 1'b1;
                    end
                    if (w_word_done) begin
                        if (w_slot_free) begin
                            out_data_d  = w_acc_merge;
                            out_keep_d  = w_keep_merge;
                            out_last_d  = in_last;
                            out_valid_d = 1'b1;
                            acc_d       = '0;
                            keep_acc_d  = '0;
                            lane_cnt_d  = '0;
                        end else begin
                            acc_d      = w_acc_merge;
                            keep_acc_d = w_keep_merge;
                            last_acc_d = in_last;
                            state_d    = HOLD;
                        end
                    end else begin
                        acc_d      = w_acc_merge;
                        keep_acc_d = w_keep_merge;
                        lane_cnt_d = lane_cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (w_slot_free) begin
                    out_data_d  = acc_q;
                    out_keep_d  = keep_acc_q;
                    out_last_d  = last_acc_q;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    keep_acc_d  = '0;
                    last_acc_d  = 1'b0;
                    lane_cnt_d  = '0;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            lane_cnt_q  <= '0;
            acc_q       <= '0;
            keep_acc_q  <= '0;
            last_acc_q  <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            nar_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_cnt_q  <= lane_cnt_d;
            acc_q       <= acc_d;
            keep_acc_q  <= keep_acc_d;
            last_acc_q  <= last_acc_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            nar_q       <= nar_d;
        end
    end

    assign in_ready  = (state_q == FILL);
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign nar_seen  = nar_q;

endmodule
`default_nettype wire

// File: tb/tb_posit_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_posit_word_packer
// Purpose  : Table-driven and scoreboard-checked bench for posit_word_packer.
// Revision : 1.0  initial release
// ============================================================================
module tb_posit_word_packer;

    localparam int P     = 16;
    localparam int LANES = 4;
    localparam int OUT_W = P * LANES;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [P-1:0]     in_posit;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic [LANES-1:0] out_keep;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;
    logic             nar_seen;

    posit_word_packer #(.P(P), .LANES(LANES), .OUT_W(OUT_W), .CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_posit  (in_posit),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .nar_seen  (nar_seen)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit rnd_mode = 1'b0;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [LANES-1:0] keep;
        logic             last;
    } word_t;

    word_t            sb_q[$];
    logic [OUT_W-1:0] m_data;
    logic [LANES-1:0] m_keep;
    int               m_lane;

    task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_data = '0;
        m_keep = '0;
        m_lane = 0;
    endtask

    // Reference packer: builds expected words from accepted pixels.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_word", {63'd0, out_valid}, '0);
                end else begin
                    word_t e;
                    e = sb_q.pop_front();
                    check("sb_data", out_data, e.data);
                    check("sb_keep", OUT_W'(out_keep), OUT_W'(e.keep));
                    check("sb_last", OUT_W'(out_last), OUT_W'(e.last));
                end
            end
            if (in_valid && in_ready) begin
                m_data[P*m_lane +: P] = in_posit;
                m_keep[m_lane]        = 1'b1;
                if (m_lane == LANES - 1 || in_last) begin
                    sb_q.push_back('{data: m_data, keep: m_keep, last: in_last});
                    model_clear();
                end else begin
                    m_lane++;
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic drive_px(input logic [P-1:0] px, input logic last, output int stalls);
        bit acc;
        acc      = 1'b0;
        stalls   = 0;
        in_posit = px;
        in_last  = last;
        in_valid = 1'b1;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            else stalls++;
            @(posedge clk);
            #1;
            if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int c;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        c = 0;
        while ((sb_q.size() != 0 || out_valid) && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("drain_queue_empty", OUT_W'(sb_q.size()), '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    typedef struct {
        logic [P-1:0]     px;
        logic             last;
        logic             done;
        logic [OUT_W-1:0] exp_data;
        logic [LANES-1:0] exp_keep;
        logic             exp_last;
        logic             exp_nar;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int st;
        int stall_total;

        vecs[0]  = '{16'h0000, 1'b0, 1'b0, 64'h0, 4'b0000, 1'b0, 1'b0};
        vecs[1]  = '{16'h4000, 1'b0, 1'b0, 64'h0, 4'b0000, 1'b0, 1'b0};
        vecs[2]  = '{16'h6000, 1'b0, 1'b0, 64'h0, 4'b0000, 1'b0, 1'b0};
        vecs[3]  = '{16'h7FBF, 1'b0, 1'b1, 64'h7FBF_6000_4000_0000, 4'b1111, 1'b0, 1'b0};
        vecs[4]  = '{16'h4000, 1'b0, 1'b0, 64'h0, 4'b0000, 1'b0, 1'b0};
        vecs[5]  = '{16'h6000, 1'b1, 1'b1, 64'h0000_0000_6000_4000, 4'b0011, 1'b1, 1'b0};
        vecs[6]  = '{16'h1234, 1'b1, 1'b1, 64'h0000_0000_0000_1234, 4'b0001, 1'b1, 1'b0};
        vecs[7]  = '{16'h0001, 1'b0, 1'b0, 64'h0, 4'b0000, 1'b0, 1'b0};
        vecs[8]  = '{16'h0002, 1'b0, 1'b0, 64'h0, 4'b0000, 1'b0, 1'b0};
        vecs[9]  = '{16'h8000, 1'b0, 1'b0, 64'h0, 4'b0000, 1'b0, 1'b1};
        vecs[10] = '{16'h0004, 1'b1, 1'b1, 64'h0004_8000_0002_0001, 4'b1111, 1'b1, 1'b1};

        model_clear();
        rst_n     = 1'b0;
        in_posit  = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", OUT_W'(out_valid), '0);
        check("rst_out_data",  out_data, '0);
        check("rst_out_keep",  OUT_W'(out_keep), '0);
        check("rst_out_last",  OUT_W'(out_last), '0);
        check("rst_nar_seen",  OUT_W'(nar_seen), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, continuous input with out_ready held high.
        for (int i = 0; i < 11; i++) begin
            drive_px(vecs[i].px, vecs[i].last, st);
            check("vec_no_stall", OUT_W'(st), '0);
            check("vec_out_valid", OUT_W'(out_valid), OUT_W'(vecs[i].done));
            check("vec_nar_seen", OUT_W'(nar_seen), OUT_W'(vecs[i].exp_nar));
            if (vecs[i].done) begin
                check("vec_out_data", out_data, vecs[i].exp_data);
                check("vec_out_keep", OUT_W'(out_keep), OUT_W'(vecs[i].exp_keep));
                check("vec_out_last", OUT_W'(out_last), OUT_W'(vecs[i].exp_last));
            end
        end
        drain();

        // Backpressure: two words fit (output reg + accumulator), then stall.
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            drive_px(16'(i), 1'b0, st);
            check("bp_accept_no_stall", OUT_W'(st), '0);
        end
        in_posit = 16'd9;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_in_ready_low", OUT_W'(in_ready), '0);
            check("bp_out_data_frozen", out_data, 64'h0004_0003_0002_0001);
            check("bp_out_valid", OUT_W'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 9; i <= 12; i++) drive_px(16'(i), 1'b0, st);
        drain();
        check("nar_sticky", OUT_W'(nar_seen), 64'd1);

        // Mid-word asynchronous reset discards the partial word.
        drive_px(16'hAAAA, 1'b0, st);
        drive_px(16'hBBBB, 1'b0, st);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("arst_out_valid", OUT_W'(out_valid), '0);
        check("arst_out_data",  out_data, '0);
        check("arst_out_keep",  OUT_W'(out_keep), '0);
        check("arst_nar_clear", OUT_W'(nar_seen), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) drive_px(16'h0100 + 16'(i), 1'b0, st);
        check("arst_new_valid", OUT_W'(out_valid), 64'd1);
        check("arst_new_data",  out_data, 64'h0103_0102_0101_0100);
        check("arst_new_keep",  OUT_W'(out_keep), 64'hF);
        drain();

        // Random valid/ready, frames of 37 pixels.
        rnd_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            idle($urandom_range(0, 2));
            drive_px(16'($urandom), (i % 37) == 36, st);
        end
        rnd_mode = 1'b0;
        drain();

        // Full-rate streaming must never stall the input.
        out_ready   = 1'b1;
        stall_total = 0;
        for (int i = 0; i < 400; i++) begin
            drive_px(16'($urandom), (i % 37) == 36, st);
            stall_total += st;
        end
        check("stream_no_stall", OUT_W'(stall_total), '0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/posit_word_packer.md
Name: posit_word_packer

Overview:
- Downstream of the combinational int-to-posit converter in the vision pixel pipe.
- Accepts a stream of P-bit posit pixels under valid/ready and packs LANES consecutive posits into one wide word for the memory/DMA write port.
- Handles frame-end flush with a zero-padded partial word and per-lane keep mask, backpressure without data loss, and sticky NaR detection.

Parameters:
- P, 16, posit width in bits (es=0 format from the converter).
- LANES, 4, posits packed per output word.
- OUT_W, P*LANES, output word width.
- CNT_W, 2, lane counter width (clog2 of LANES).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_posit  input  P  posit pixel from converter.
- in_valid  input  1  in_posit is valid this cycle.
- in_last  input  1  qualifies the last pixel of a frame (meaningful only with in_valid).
- in_ready  output  1  packer accepts in_posit this cycle.
- out_data  output  OUT_W  packed word; lane i occupies bits [P*i+P-1 : P*i], lane 0 is the earliest pixel.
- out_keep  output  LANES  bit i = 1 if lane i holds a real pixel.
- out_last  output  1  word contains the frame's last pixel.
- out_valid  output  1  out_data/out_keep/out_last valid.
- out_ready  input  1  consumer accepts the output word.
- nar_seen  output  1  sticky flag: an input equal to NaR (1 followed by P-1 zeros) was accepted.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_keep=0, out_last=0, nar_seen=0, lane counter=0, accumulator=0, FSM=FILL. Reset mid-word discards the partial word; nothing is emitted for it.
- Handshakes: input transfer when in_valid&in_ready; output transfer when out_valid&out_ready. out_data/keep/last are stable while out_valid=1 and out_ready=0.
- slot_free = !out_valid | out_ready.
- FSM FILL: in_ready=1.
  - Each accept writes in_posit into accumulator lane lane_cnt and sets the matching keep bit.
  - A word completes when the accepted pixel is in lane LANES-1 or carries in_last.
  - On completion with slot_free: merge the current pixel, load the output register, set out_valid=1 next cycle, clear the accumulator/keep, lane_cnt=0, stay FILL.
  - On completion without slot_free: hold the completed word in the accumulator, go HOLD.
  - Otherwise lane_cnt increments.
- FSM HOLD: in_ready=0. When slot_free, move the accumulator to the output register, clear it, lane_cnt=0, go FILL.
- out_valid clears on an output transfer unless a new word loads in the same cycle. Simultaneous drain and load is legal and gives back-to-back words.
- Latency: out_valid rises the cycle after the accept that completes the word.
- Throughput: with out_ready held 1, one word per LANES accepted pixels, no input bubbles.
- Partial word: on in_last, unfilled lanes are 0 and their keep bits 0; out_last=1. A full word with in_last on lane LANES-1 has keep all ones and out_last=1.
- in_last on lane 0 gives keep=0001.
- Empty frames are never emitted.
- nar_seen sets on accept of NaR, clears only on reset. The pixel is still packed unchanged.

Test Plan:
- Reset, out_ready=1; send 0x0000, 0x4000, 0x6000, 0x7FBF with in_last=0 -> one cycle after 4th accept: out_valid=1, out_data=0x7FBF_6000_4000_0000, out_keep=1111, out_last=0; in_ready never drops.
- Send 0x4000, then 0x6000 with in_last=1 -> out_data=0x0000_0000_6000_4000, out_keep=0011, out_last=1.
- Hold out_ready=0, offer 12 continuous pixels 1..12 -> exactly 8 accepted; in_ready=0 from the cycle after the 8th; out_data frozen at the first word. Release out_ready -> words {4,3,2,1}, {8,7,6,5}, then {12,11,10,9} after remaining accepts; no loss or reorder.
- Accept 2 pixels, pulse rst_n low mid-cycle -> outputs zero immediately. After release, 4 new pixels produce a word with only the new pixels and keep=1111.
- Accept 0x8000 inside a word -> nar_seen=1 from the next cycle and stays 1 through later frames; 0x8000 appears in its lane.
- Random in_valid/out_ready over 400 pixels with in_last every 37 -> scoreboard matches all data/keep/last and finds no duplicates; with out_ready=1 throughout, no input stall cycles.
